// File: rtl/seg_frame_scheduler_if.sv
// Frame sources, message request and serial display link between the game
// logic and the seven-segment frame scheduler.
interface seg_frame_scheduler_if;
  logic [63:0] score_frame;
  logic [63:0] msg_frame;
  logic        msg_req;
  logic        msg_busy;
  logic        frame_done;
  logic        SEGCLK;
  logic        SEGCLR;
  logic        SEGDT;
  logic        SEGEN;

  modport master (
    output score_frame, msg_frame, msg_req,
    input  msg_busy, frame_done, SEGCLK, SEGCLR, SEGDT, SEGEN
  );

  modport slave (
    input  score_frame, msg_frame, msg_req,
    output msg_busy, frame_done, SEGCLK, SEGCLR, SEGDT, SEGEN
  );
endinterface

// File: rtl/seg_frame_scheduler.sv
// Picks the score or the held message frame at each LATCH and shifts it MSB-first
// onto the 8-digit serial seven-segment link. The display is refreshed continuously.
module seg_frame_scheduler #(
  parameter int CLK_DIV     = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int HOLD_W      = 27
) (
  input  logic                   clk,
  input  logic                   rst,
  seg_frame_scheduler_if.slave   sif
);
  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HI   = PH_W'(CLK_DIV);

  state_t              state_q, state_d;
  logic [63:0]         sr_q, sr_d;
  logic [5:0]          bit_q, bit_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [63:0]         buf_q, buf_d;
  logic                busy_q, busy_d;
  logic                segclk_q, segclk_d;
  logic                segdt_q, segdt_d;
  logic                done_q, done_d;
  logic                segclr_q, segen_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LATCH;
      LATCH:   state_d = SHIFT;
      SHIFT:   if (ph_q == PH_LAST && bit_q == 6'd0) state_d = DONE;
      DONE:    state_d = LATCH;
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath and link outputs are computed from the next state so the
  // pins come straight from flops.
  always_comb begin
    sr_d  = sr_q;
    bit_d = bit_q;
    ph_d  = ph_q;
    case (state_q)
      LATCH: begin
        sr_d  = busy_q ? buf_q : sif.score_frame;
        bit_d = 6'd63;
        ph_d  = '0;
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q != 6'd0) begin
            sr_d  = {sr_q[62:0], 1'b0};
            bit_d = bit_q - 6'd1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: ;
    endcase
    segclk_d = (state_d == SHIFT) && (ph_d >= PH_HI);
    segdt_d  = (state_d == SHIFT) && sr_d[63];
    done_d   = (state_d == DONE);
  end

  // A new request always wins over the countdown and restarts the hold.
  always_comb begin
    buf_d  = buf_q;
    hold_d = hold_q;
    if (sif.msg_req) begin
      buf_d  = sif.msg_frame;
      hold_d = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    busy_d = (hold_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      bit_q    <= '0;
      ph_q     <= '0;
      hold_q   <= '0;
      buf_q    <= '0;
      busy_q   <= 1'b0;
      segclk_q <= 1'b0;
      segdt_q  <= 1'b0;
      done_q   <= 1'b0;
      segclr_q <= 1'b0;
      segen_q  <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      ph_q     <= ph_d;
      hold_q   <= hold_d;
      buf_q    <= buf_d;
      busy_q   <= busy_d;
      segclk_q <= segclk_d;
      segdt_q  <= segdt_d;
      done_q   <= done_d;
      segclr_q <= 1'b1;
      segen_q  <= 1'b1;
    end
  end

  assign sif.SEGCLK     = segclk_q;
  assign sif.SEGDT      = segdt_q;
  assign sif.SEGCLR     = segclr_q;
  assign sif.SEGEN      = segen_q;
  assign sif.frame_done = done_q;
  assign sif.msg_busy   = busy_q;
endmodule

// File: tb/tb_seg_frame_scheduler.sv
// Directed bench for seg_frame_scheduler: reset, serialization, message hold,
// mid-frame requests, re-trigger and reset during shifting.
module tb_seg_frame_scheduler;
  localparam int CLK_DIV = 2;
  localparam int HOLD    = 1000;
  localparam int PERIOD  = 128 * CLK_DIV + 2;

  localparam logic [63:0] S2 = 64'h92C6C08886C0F9A4;
  localparam logic [63:0] S3 = 64'h0123456789ABCDEF;
  localparam logic [63:0] M3 = 64'hFFFF0000FFFF0000;
  localparam logic [63:0] M4 = 64'h5A5AC3C30F0F9669;
  localparam logic [63:0] M5 = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] S6 = 64'hC0FFEE0000100035;

  logic gclk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  seg_frame_scheduler_if sif();

  seg_frame_scheduler #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD), .HOLD_W(27)) dut (
    .clk (gclk),
    .rst (rst),
    .sif (sif)
  );

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  // Frame capture: SEGDT sampled at each SEGCLK rise, frame closed on frame_done.
  logic [63:0] acc = '0;
  int          nb = 0;
  logic        prev_clk = 1'b0;
  logic [63:0] frm_q[$];
  int          nb_q[$];
  int          dc_q[$];

  always @(negedge gclk) begin
    if (rst) begin
      acc = '0;
      nb  = 0;
    end else begin
      if (sif.SEGCLK && !prev_clk) begin
        acc = {acc[62:0], sif.SEGDT};
        nb  = nb + 1;
      end
      if (sif.frame_done) begin
        frm_q.push_back(acc);
        nb_q.push_back(nb);
        dc_q.push_back(cyc);
        acc = '0;
        nb  = 0;
      end
    end
    prev_clk = sif.SEGCLK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic flush();
    frm_q.delete();
    nb_q.delete();
    dc_q.delete();
  endtask

  function automatic logic [63:0] qf(int i);
    if (i < frm_q.size()) return frm_q[i];
    return 'x;
  endfunction

  function automatic logic [63:0] qn(int i);
    if (i < nb_q.size()) return 64'(nb_q[i]);
    return 'x;
  endfunction

  function automatic logic [63:0] qd(int i);
    if (i + 1 < dc_q.size()) return 64'(dc_q[i+1] - dc_q[i]);
    return 'x;
  endfunction

  task automatic wait_done();
    int k = 0;
    while (sif.frame_done !== 1'b1 && k < 2 * PERIOD) begin
      tick();
      k++;
    end
    if (sif.frame_done !== 1'b1) chk("wait_done", 0, 1);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frm_q.size() < n && k < (n + 1) * PERIOD) begin
      tick();
      k++;
    end
    if (frm_q.size() < n) chk("wait_frames", 64'(frm_q.size()), 64'(n));
  endtask

  task automatic wait_rises(input int n);
    int   k = 0;
    int   r = 0;
    logic p = sif.SEGCLK;
    while (r < n && k < 2 * PERIOD) begin
      tick();
      k++;
      if (sif.SEGCLK && !p) r++;
      p = sif.SEGCLK;
    end
    if (r < n) chk("wait_rises", 64'(r), 64'(n));
  endtask

  initial begin
    int k;
    int c1;
    int lows;
    rst = 1'b1;
    sif.score_frame = S2;
    sif.msg_frame   = '0;
    sif.msg_req     = 1'b0;

    // 1: reset values, then enable and first rise timing
    repeat (3) tick();
    chk("rst_segclk", sif.SEGCLK, 0);
    chk("rst_segdt", sif.SEGDT, 0);
    chk("rst_segclr", sif.SEGCLR, 0);
    chk("rst_segen", sif.SEGEN, 0);
    chk("rst_done", sif.frame_done, 0);
    chk("rst_busy", sif.msg_busy, 0);
    rst = 1'b0;
    flush();
    tick();
    chk("rel_segclr", sif.SEGCLR, 1);
    chk("rel_segen", sif.SEGEN, 1);
    k = 1;
    while (sif.SEGCLK !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("first_rise", 64'(k), 4);

    // 2: score serialization, repeated frames and frame period
    wait_frames(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("score_frame%0d", i), qf(i), S2);
      chk($sformatf("score_bits%0d", i), qn(i), 64);
    end
    chk("period0", qd(0), PERIOD);
    chk("period1", qd(1), PERIOD);

    // 3: request between frames, hold length, return to score
    wait_done();
    sif.score_frame = S3;
    sif.msg_frame   = M3;
    sif.msg_req     = 1'b1;
    tick();
    sif.msg_req     = 1'b0;
    flush();
    k = 0;
    while (sif.msg_busy === 1'b1 && k < 2 * HOLD) begin
      k++;
      tick();
    end
    chk("hold_len", 64'(k), HOLD);
    wait_frames(5);
    for (int i = 0; i < 4; i++) chk($sformatf("msg_frame%0d", i), qf(i), M3);
    chk("after_hold", qf(4), S3);

    // 4: request at bit 30 leaves the frame in flight alone
    wait_done();
    tick();
    flush();
    wait_rises(34);
    sif.msg_frame = M4;
    sif.msg_req   = 1'b1;
    tick();
    sif.msg_req   = 1'b0;
    c1 = cyc;
    wait_frames(2);
    chk("midreq_cur", qf(0), S3);
    chk("midreq_next", qf(1), M4);

    // 5: re-trigger 500 cycles after the first request
    lows = 0;
    while (cyc < c1 + 499) begin
      if (sif.msg_busy !== 1'b1) lows++;
      tick();
    end
    chk("busy_between", 64'(lows), 0);
    sif.msg_frame = M5;
    sif.msg_req   = 1'b1;
    tick();
    sif.msg_req   = 1'b0;
    flush();
    k = 0;
    while (sif.msg_busy === 1'b1 && k < 2 * HOLD) begin
      k++;
      tick();
    end
    chk("retrig_len", 64'(k), HOLD);
    chk("retrig_cur", qf(0), M4);
    chk("retrig_next", qf(1), M5);

    // 6: reset at bit 20, then a clean score frame
    sif.score_frame = S6;
    wait_done();
    tick();
    flush();
    wait_rises(10);
    sif.msg_frame = 64'h1111111111111111;
    sif.msg_req   = 1'b1;
    tick();
    sif.msg_req   = 1'b0;
    wait_rises(34);
    chk("pre_rst_segdt", sif.SEGDT, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_segclk", sif.SEGCLK, 0);
    chk("mid_rst_segdt", sif.SEGDT, 0);
    chk("mid_rst_segclr", sif.SEGCLR, 0);
    chk("mid_rst_segen", sif.SEGEN, 0);
    chk("mid_rst_busy", sif.msg_busy, 0);
    tick();
    rst = 1'b0;
    flush();
    wait_frames(1);
    chk("post_rst_frame", qf(0), S6);
    chk("post_rst_bits", qn(0), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
